// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory / MMIO responder.
package mem_pkg;

  typedef logic [2:0] len_t;

  localparam len_t LEN_NONE = 3'd0;
  localparam len_t LEN_B    = 3'd1;
  localparam len_t LEN_H    = 3'd2;
  localparam len_t LEN_W    = 3'd3;
  localparam len_t LEN_BU   = 3'd5;
  localparam len_t LEN_HU   = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] TEST_ADDR_DEFAULT = 32'hFFFF_FFF0;

  // Replace one little-endian byte lane of a word.
  function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [7:0] data,
                                             input logic [1:0] lane);
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      default: res[31:24] = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_lane_unit.sv
// Lane steering: store merge, load extract/extend, and alignment / length-code checks.
module lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  len_t        len,
  input  logic [1:0]  lane,
  output logic [31:0] new_word,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        len_ok
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Select the addressed lanes, then merge/extend according to the length code
  always_comb begin
    sel_byte   = old_word[7:0];
    sel_half   = old_word[15:0];
    new_word   = old_word;
    rdata      = 32'd0;
    misaligned = 1'b0;
    len_ok     = 1'b1;
    case (lane)
      2'd0:    sel_byte = old_word[7:0];
      2'd1:    sel_byte = old_word[15:8];
      2'd2:    sel_byte = old_word[23:16];
      default: sel_byte = old_word[31:24];
    endcase
    if (lane[1]) begin
      sel_half = old_word[31:16];
    end else begin
      sel_half = old_word[15:0];
    end
    case (len)
      LEN_NONE: new_word = old_word;
      LEN_B: begin
        rdata    = {{24{sel_byte[7]}}, sel_byte};
        new_word = merge_byte(old_word, wdata[7:0], lane);
      end
      LEN_BU: begin
        rdata    = {24'd0, sel_byte};
        new_word = merge_byte(old_word, wdata[7:0], lane);
      end
      LEN_H, LEN_HU: begin
        misaligned = lane[0];
        if (len == LEN_H) begin
          rdata = {{16{sel_half[15]}}, sel_half};
        end else begin
          rdata = {16'd0, sel_half};
        end
        if (lane[1]) begin
          new_word = {wdata[15:0], old_word[15:0]};
        end else begin
          new_word = {old_word[31:16], wdata[15:0]};
        end
      end
      LEN_W: begin
        misaligned = (lane != 2'd0);
        rdata      = old_word;
        new_word   = wdata;
      end
      default: len_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data RAM / test-I/O responder with programmable wait states.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] TEST_ADDR   = TEST_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  len_t        req_len,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic [31:0] testin,
  output logic [31:0] testout
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic        lat_we;
  len_t        lat_len;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] ram [DEPTH_WORDS];

  logic        cur_we;
  len_t        cur_len;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        ram_hit;
  logic        tst_hit;
  logic        len_ok;
  logic        misaligned;
  logic        err;
  logic        do_write;
  logic [31:0] old_word;
  logic [31:0] new_word;
  logic [31:0] ext_data;
  logic [31:0] rdata_out;

  // With zero wait states the response is formed straight from the bus in IDLE
  always_comb begin
    if (state == IDLE) begin
      cur_we    = req_we;
      cur_len   = req_len;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = lat_we;
      cur_len   = lat_len;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
    end
  end

  assign ram_hit  = cur_addr[31:2] < 30'(DEPTH_WORDS);
  assign tst_hit  = !ram_hit && (cur_addr[31:2] == TEST_ADDR[31:2]);
  assign old_word = tst_hit ? testin : ram[cur_addr[AW+1:2]];

  lane_unit u_lane (
    .old_word  (old_word),
    .wdata     (cur_wdata),
    .len       (cur_len),
    .lane      (cur_addr[1:0]),
    .new_word  (new_word),
    .rdata     (ext_data),
    .misaligned(misaligned),
    .len_ok    (len_ok)
  );

  // Error classification; LEN_NONE is a clean no-op regardless of address
  always_comb begin
    err = 1'b0;
    if (cur_len == LEN_NONE) begin
      err = 1'b0;
    end else if (!len_ok || misaligned) begin
      err = 1'b1;
    end else if (tst_hit) begin
      err = cur_we && (cur_len != LEN_W);
    end else if (ram_hit) begin
      err = 1'b0;
    end else begin
      err = 1'b1;
    end
  end

  assign do_write  = cur_we && !err && (cur_len != LEN_NONE);
  assign rdata_out = (err || cur_we) ? 32'd0 : ext_data;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = (WAIT_LAST == 4'd0) ? RESP : WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt >= WAIT_LAST) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM, request latch, registered response and test output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      lat_we     <= 1'b0;
      lat_len    <= LEN_NONE;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      testout    <= 32'd0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == IDLE);
      if (state == IDLE && req_valid) begin
        lat_we    <= req_we;
        lat_len   <= req_len;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (state_next == WAIT) begin
        wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd1;
      end else begin
        wait_cnt <= 4'd0;
      end
      resp_valid <= (state_next == RESP);
      resp_rdata <= (state_next == RESP) ? rdata_out : 32'd0;
      resp_err   <= (state_next == RESP) && err;
      if (state == RESP && do_write && tst_hit) begin
        testout <= cur_wdata;
      end
    end
  end

  // RAM write commits on the RESP edge; a reset in that cycle cancels it
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && do_write && ram_hit) begin
      ram[cur_addr[AW+1:2]] <= new_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=1, DEPTH_WORDS=1024).
module tb_dmem_responder;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  len_t        req_len;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] testin;
  logic [31:0] testout;

  int vectors;
  int miscompares;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .TEST_ADDR(32'hFFFF_FFF0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_len(req_len), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .testin(testin), .testout(testout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction; lat counts cycles from the accept cycle to the resp_valid cycle (-1 = none)
  task automatic xact(input logic we, input len_t len, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = we; req_len = len; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    if (!resp_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 ||
        resp_err !== 1'b0 || testout !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b testout=%h want 1 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, testout);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, LEN_W, 32'h10, 32'h1234_5678, rd, er, lat);
    vectors++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'd0) begin
      miscompares++;
      $display("FAIL word_store: got lat=%0d err=%b rdata=%h want lat=2 err=0 rdata=0", lat, er, rd);
    end
    xact(1'b0, LEN_W, 32'h10, 32'h0, rd, er, lat);
    vectors++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL word_load: got lat=%0d err=%b rdata=%h want lat=2 err=0 rdata=12345678", lat, er, rd);
    end
  endtask

  task automatic test_extension();
    logic [31:0] rd; logic er; int lat;
    len_t        lens [4] = '{LEN_B, LEN_BU, LEN_H, LEN_HU};
    logic [31:0] adrs [4] = '{32'h22, 32'h23, 32'h22, 32'h20};
    logic [31:0] exps [4] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    xact(1'b1, LEN_W, 32'h20, 32'h80FF_7F01, rd, er, lat);
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, lens[i], adrs[i], 32'h0, rd, er, lat);
      vectors++;
      if (rd !== exps[i] || er !== 1'b0 || lat !== 2) begin
        miscompares++;
        $display("FAIL extend_%0d: got rdata=%h err=%b lat=%0d want rdata=%h err=0 lat=2",
                 i, rd, er, lat, exps[i]);
      end
    end
  endtask

  task automatic test_merge();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, LEN_W, 32'h30, 32'hAABB_CCDD, rd, er, lat);
    xact(1'b1, LEN_B, 32'h31, 32'h0000_0011, rd, er, lat);
    xact(1'b0, LEN_W, 32'h30, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== 32'hAABB_11DD || er !== 1'b0) begin
      miscompares++;
      $display("FAIL merge_byte: got %h err=%b want AABB11DD err=0", rd, er);
    end
    xact(1'b1, LEN_H, 32'h32, 32'h0000_2233, rd, er, lat);
    xact(1'b0, LEN_W, 32'h30, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== 32'h2233_11DD || er !== 1'b0) begin
      miscompares++;
      $display("FAIL merge_half: got %h err=%b want 223311DD err=0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    xact(1'b0, LEN_W, 32'h31, 32'h0, rd, er, lat);
    vectors++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      miscompares++;
      $display("FAIL misaligned_word_load: got err=%b rdata=%h want err=1 rdata=0", er, rd);
    end
    xact(1'b1, LEN_H, 32'h33, 32'h0000_FFFF, rd, er, lat);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL misaligned_half_store: got err=%b want 1", er);
    end
    xact(1'b0, LEN_W, 32'h30, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== 32'h2233_11DD) begin
      miscompares++;
      $display("FAIL ram_after_bad_store: got %h want 223311DD", rd);
    end
    xact(1'b0, LEN_W, 32'h0010_0000, 32'h0, rd, er, lat);
    vectors++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      miscompares++;
      $display("FAIL unmapped_load: got err=%b rdata=%h want err=1 rdata=0", er, rd);
    end
    xact(1'b0, 3'd7, 32'h10, 32'h0, rd, er, lat);
    vectors++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      miscompares++;
      $display("FAIL bad_len7: got err=%b rdata=%h want err=1 rdata=0", er, rd);
    end
    xact(1'b0, 3'd4, 32'h10, 32'h0, rd, er, lat);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_len4: got err=%b want 1", er);
    end
    xact(1'b0, LEN_NONE, 32'h0010_0000, 32'h0, rd, er, lat);
    vectors++;
    if (er !== 1'b0 || rd !== 32'd0 || lat !== 2) begin
      miscompares++;
      $display("FAIL len_none: got err=%b rdata=%h lat=%0d want err=0 rdata=0 lat=2", er, rd, lat);
    end
  endtask

  task automatic test_testio();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, LEN_W, 32'hFFFF_FFF0, 32'hCAFE_BABE, rd, er, lat);
    @(negedge clk);
    vectors++;
    if (testout !== 32'hCAFE_BABE || er !== 1'b0) begin
      miscompares++;
      $display("FAIL testout_write: got %h err=%b want CAFEBABE err=0", testout, er);
    end
    xact(1'b1, LEN_B, 32'hFFFF_FFF0, 32'h0000_0055, rd, er, lat);
    @(negedge clk);
    vectors++;
    if (er !== 1'b1 || testout !== 32'hCAFE_BABE) begin
      miscompares++;
      $display("FAIL testout_byte_store: got err=%b testout=%h want err=1 testout=CAFEBABE", er, testout);
    end
    testin = 32'h0000_00F5;
    xact(1'b0, LEN_B, 32'hFFFF_FFF0, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== 32'hFFFF_FFF5 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL testin_byte_load: got %h err=%b want FFFFFFF5 err=0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    int first; int second; int resp_at; int c;
    first = -1; second = -1; resp_at = -1; c = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_len = LEN_W; req_addr = 32'h10; req_wdata = 32'h0;
    while (second < 0 && c < 20) begin
      if (resp_valid && resp_at < 0) resp_at = c;
      if (req_ready) begin
        if (first < 0) first = c;
        else second = c;
      end
      if (second < 0) begin
        @(negedge clk);
        c++;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (first !== 0 || second - first !== 3) begin
      miscompares++;
      $display("FAIL b2b_interval: got first=%0d second=%0d want first=0 interval=3", first, second);
    end
    vectors++;
    if (resp_at - first !== 2) begin
      miscompares++;
      $display("FAIL b2b_latency: got %0d want 2", resp_at - first);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat; logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_len = LEN_W; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || testout !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_state: got ready=%b valid=%b testout=%h want 1 0 0", req_ready, resp_valid, testout);
    end
    seen = 1'b0;
    repeat (5) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_resp: got resp seen=%b want 0", seen);
    end
    xact(1'b0, LEN_W, 32'h10, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== 32'h1234_5678 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_ram: got %h err=%b want 12345678 err=0", rd, er);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_len = LEN_NONE;
    req_addr = 32'd0; req_wdata = 32'd0; testin = 32'd0;
    test_reset();
    test_word();
    test_extension();
    test_merge();
    test_errors();
    test_testio();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory and MMIO responder on the far end of the CPU memory-stage bus.
- The CPU memory stage is the initiator. It issues address, write data, access length and write enable. This block accepts one request at a time, inserts configurable wait states, performs the word/half/byte access, and returns sign- or zero-extended read data plus an error flag.
- It also owns the test I/O port: a readable `testin` and a writable `testout` register.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in data RAM (power of two)
- WAIT_CYCLES, 1, wait states between accept and response (0..15)
- TEST_ADDR, 32'hFFFF_FFF0, word address of the test I/O register; reads return `testin`, writes update `testout`

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1=store, 0=load
- req_len  in  3  access length/extension code (package constants)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; misaligned or unmapped access
- testin  in  32  external test input, sampled on a TEST_ADDR load
- testout  out  32  test output register

Behaviour:
- Reset (synchronous, active-high) forces state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, testout=0, wait counter=0. RAM contents are not cleared.
- Reset mid-operation aborts the pending request. No RAM or testout write occurs, and no response is issued.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch we/len/addr/wdata. Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: counter counts 1..WAIT_CYCLES. On reaching WAIT_CYCLES, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle; the RAM/testout write commits on this cycle's edge. Then go to IDLE.
- Latency: resp_valid is asserted WAIT_CYCLES+1 cycles after the accept edge. Minimum issue interval is WAIT_CYCLES+2 cycles, because req_ready is low in WAIT and RESP.
- req_len encoding:
  - LEN_NONE=0: treated as a no-op; responds with err=0, rdata=0, no write.
  - LEN_B=1: byte, sign-extended.
  - LEN_H=2: half, sign-extended.
  - LEN_W=3: word.
  - LEN_BU=5: byte, zero-extended.
  - LEN_HU=6: half, zero-extended.
  - Any other code gives err=1.
- Alignment: half requires addr[0]=0 and word requires addr[1:0]=0; otherwise err=1. Byte accesses are never misaligned.
- Mapping:
  - RAM when addr[31:2] < DEPTH_WORDS, indexed by addr[31:2].
  - Test register when addr[31:2]==TEST_ADDR[31:2].
  - Otherwise unmapped: err=1.
- Lane select is little-endian: byte lane addr[1:0], half lane addr[1].
- Stores are read-modify-write of the addressed word; only the selected lanes change.
- Test register:
  - Word store only; byte/half stores to it give err=1.
  - Loads of any length return `testin` lanes, extended per req_len.
- Any error suppresses the write and forces resp_rdata=0.
- req_valid while req_ready=0 is ignored: no queuing, and the initiator must hold the request.
- resp_rdata/resp_err are valid only while resp_valid=1; they are 0 otherwise.

Decomposition:
- Shared package (mem_pkg):
  - LEN_* codes and the 3-bit len type.
  - FSM state enum {IDLE, WAIT, RESP}.
  - Default TEST_ADDR constant.
- One natural sub-module, lane_unit (combinational): store lane merge (old word, wdata, len, addr[1:0] → new word) and load extract/extend (word, len, addr[1:0] → rdata), plus the alignment check.
- The FSM, RAM array and testout register live in dmem_responder.

Test Plan:
- Reset, then a word store then load: store 0x12345678 to 0x10, load word from 0x10 (WAIT_CYCLES=1) → resp_valid 2 cycles after each accept; rdata=0x12345678, err=0.
- Extension: store word 0x80FF7F01 to 0x20; loads give:
  - LEN_B @0x22 → 0xFFFFFFFF
  - LEN_BU @0x23 → 0x00000080
  - LEN_H @0x22 → 0xFFFF80FF
  - LEN_HU @0x20 → 0x00007F01
- Partial store merge: word 0xAABBCCDD at 0x30, then LEN_B store 0x11 to 0x31 → word reads 0xAABB11DD; a LEN_H store of 0x2233 to 0x32 then gives 0x223311DD.
- Errors:
  - LEN_W load at 0x31 → err=1, rdata=0.
  - LEN_H store at 0x33 → err=1, RAM unchanged.
  - Load at 0x0010_0000 with DEPTH_WORDS=1024 → err=1.
  - req_len=7 → err=1.
- Test I/O: word store 0xCAFEBABE to TEST_ADDR → testout=0xCAFEBABE on the RESP edge. With testin=0x000000F5, LEN_B load from TEST_ADDR → 0xFFFFFFF5.
- Handshake and reset:
  - Back-to-back req_valid held high → second accept exactly WAIT_CYCLES+2 cycles after the first.
  - rst pulsed during WAIT of a store → no resp_valid, target word unchanged, testout=0, req_ready=1 the cycle after reset.
